// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder built from gate primitives; time-shared by serial_adder_ctrl.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic carryin,
  output logic sum,
  output logic carryout
);

  wire ab_xor;
  wire ab_and;
  wire prop_and;
  wire sum_w;
  wire cout_w;

  xor g_xor_ab  (ab_xor, a, b);
  xor g_xor_sum (sum_w, ab_xor, carryin);
  and g_and_ab  (ab_and, a, b);
  and g_and_p   (prop_and, ab_xor, carryin);
  or  g_or_c    (cout_w, ab_and, prop_and);

  assign sum      = sum_w;
  assign carryout = cout_w;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Adds two WIDTH-bit operands LSB first through a single full-adder cell,
// one bit per clock, with valid/ready handshakes on both sides.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int unsigned   CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // Compare against WIDTH-1 rather than waiting for a wrap, so odd widths stop on time.
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carryout_q, carryout_d;
  logic             overflow_q, overflow_d;

  logic cell_sum;
  logic cell_cout;
  logic last_bit;

  full_adder_cell u_cell (
    .a        (a_sr_q[0]),
    .b        (b_sr_q[0]),
    .carryin  (carry_q),
    .sum      (cell_sum),
    .carryout (cell_cout)
  );

  assign last_bit = (cnt_q == LAST_BIT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every comb output gets a default first; a missing branch would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = ADD;
      ADD:     if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Handshake outputs depend on state only, never combinationally on in_valid/out_ready.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    a_sr_d     = a_sr_q;
    b_sr_d     = b_sr_q;
    sum_sr_d   = sum_sr_q;
    sum_d      = sum_q;
    carryout_d = carryout_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = carryin;
          cnt_d   = '0;
        end
      end
      ADD: begin
        sum_sr_d = {cell_sum, sum_sr_q[WIDTH-1:1]};
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        carry_d  = cell_cout;
        cnt_d    = cnt_q + CW'(1);
        if (last_bit) begin
          // Result registers update only here, so they hold through DONE and the following IDLE.
          sum_d      = {cell_sum, sum_sr_q[WIDTH-1:1]};
          carryout_d = cell_cout;
          overflow_d = carry_q ^ cell_cout;
        end
      end
      default: ;
    endcase
  end

  // NOTE: shift registers are cleared on reset too, so a stale result never reappears after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      a_sr_q     <= '0;
      b_sr_q     <= '0;
      sum_sr_q   <= '0;
      sum_q      <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      a_sr_q     <= a_sr_d;
      b_sr_q     <= b_sr_d;
      sum_sr_q   <= sum_sr_d;
      sum_q      <= sum_d;
      carryout_q <= carryout_d;
      overflow_q <= overflow_d;
    end
  end

  assign sum      = sum_q;
  assign carryout = carryout_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): directed cases plus
// randomized operations against an arithmetic reference model.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carryin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carryout;
  logic         overflow;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_acc = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carryin   (carryin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carryout  (carryout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drives one operation from IDLE (called at a negedge) and returns at the negedge
  // after the result handshake. exp_int > 0 checks the cycles since the previous accept.
  task automatic run_op(input logic [W-1:0] a_i, input logic [W-1:0] b_i, input logic cin_i,
                        input int stall, input bit junk, input int exp_int);
    int          full;
    logic [W-1:0] es;
    logic        ec;
    logic        eo;
    int          lat;
    full = int'(a_i) + int'(b_i) + int'(cin_i);
    es   = full[W-1:0];
    ec   = full[W];
    eo   = (a_i[W-1] == b_i[W-1]) && (es[W-1] != a_i[W-1]);

    check("idle_in_ready", in_ready, 1);
    in_valid  = 1'b1;
    a         = a_i;
    b         = b_i;
    carryin   = cin_i;
    out_ready = (stall == 0);
    if (exp_int > 0) check("accept_interval", cyc - last_acc, exp_int);
    last_acc = cyc;
    @(negedge clk);
    check("busy_in_ready", in_ready, 0);
    check("busy_out_valid", out_valid, 0);
    lat = 0;
    while (!out_valid && lat < 30) begin
      if (junk) begin
        in_valid = 1'b1;
        a        = W'($urandom);
        b        = W'($urandom);
        carryin  = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, W);
    check("sum", sum, es);
    check("carryout", carryout, ec);
    check("overflow", overflow, eo);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_sum", sum, es);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int prev_stall;
    int st;
    bit jk;

    reset     = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    carryin   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_carryout", carryout, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;
    @(negedge clk);

    run_op(8'h00, 8'h00, 1'b0, 0, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, W + 2);
    run_op(8'h7F, 8'h01, 1'b0, 0, 1'b0, W + 2);
    run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0, W + 2);
    run_op(8'h80, 8'h80, 1'b0, 0, 1'b0, W + 2);
    run_op(8'h35, 8'h4A, 1'b0, 5, 1'b0, W + 2);

    // Reset during the third ADD cycle discards the operation.
    in_valid = 1'b1;
    a        = 8'h12;
    b        = 8'h34;
    carryin  = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_carryout", carryout, 0);
    @(negedge clk);
    reset = 1'b0;
    seen  = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_valid_after_rst", seen, 0);
    run_op(8'h12, 8'h34, 1'b0, 0, 1'b0, 0);

    run_op(8'h5A, 8'hA5, 1'b1, 0, 1'b1, W + 2);

    prev_stall = 0;
    for (int n = 0; n < 40; n++) begin
      st = int'($urandom_range(0, 3));
      jk = 1'($urandom);
      run_op(W'($urandom), W'($urandom), 1'($urandom), st, jk, W + 2 + prev_stall);
      prev_stall = st;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Sequencer that adds two WIDTH-bit operands using a single one-bit full-adder cell, LSB first, one bit per clock.
- Accepts an operand pair on a valid/ready input handshake, iterates the cell WIDTH times through a carry flop, and presents the sum, carry-out and signed overflow on a valid/ready output handshake.
- It is the sequential wrapper that time-shares the bit-level adder for wide operations.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair and carryin are valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- carryin  input  1  carry into bit 0.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  a + b + carryin, modulo 2^WIDTH.
- carryout  output  1  carry out of bit WIDTH-1.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Clocking and reset: one clock, clk. reset is asynchronous, active-high.
- Reset state:
  - FSM in IDLE; bit counter = 0; carry flop = 0.
  - Operand and sum shift registers = 0.
  - in_ready = 1, out_valid = 0, sum = 0, carryout = 0, overflow = 0.
- FSM states: IDLE, ADD, DONE (2-bit encoding).
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid=1, the pair is accepted: load the a/b shift registers, load the carry flop with carryin, clear the counter, go to ADD.
  - in_valid=0: stay in IDLE.
- ADD:
  - in_ready = 0, out_valid = 0.
  - Each cycle the cell sees a_sr[0], b_sr[0] and the carry flop.
  - On the edge:
    - shift the cell sum into sum_sr MSB (sum_sr shifts right);
    - shift a_sr and b_sr right;
    - carry flop takes the cell carry-out;
    - counter increments.
  - When counter == WIDTH-1 on the edge:
    - capture the carry into the MSB (the carry flop value) for overflow;
    - capture the cell carry-out as carryout;
    - go to DONE.
  - Exactly WIDTH ADD cycles.
- DONE:
  - out_valid = 1; sum, carryout and overflow are stable and held.
  - Edge with out_ready=1: go to IDLE.
  - out_ready=0: hold all outputs indefinitely.
  - in_ready = 0; no bypass from DONE straight to ADD.
- Latency and throughput:
  - Accept edge E0; out_valid rises after edge E_WIDTH.
  - Minimum interval between accepts is WIDTH+2 cycles.
- in_valid asserted during ADD/DONE is ignored; a, b and carryin are not sampled.
- out_ready asserted outside DONE has no effect.
- The sum, carryout and overflow registers keep the last result after returning to IDLE, until the next completion; only out_valid qualifies them.
- Reset asserted mid-ADD or in DONE:
  - immediately return to the reset state;
  - the in-flight operation is discarded, with no out_valid pulse.
- Width rule: the counter is $clog2(WIDTH) bits; the counter compare is to WIDTH-1, so a non-power-of-two WIDTH must not wrap early.
- No combinational path from in_valid or out_ready to in_ready or out_valid.

Decomposition:
- Shared package serial_adder_pkg holds:
  - the state typedef (IDLE=2'd0, ADD=2'd1, DONE=2'd2);
  - the default WIDTH constant.
- One sub-module: full_adder_cell (a, b, carryin → sum, carryout), built from gate primitives and instantiated once.
- FSM, counter, shift registers and carry flop live in serial_adder_ctrl.

Test Plan:
All cases use WIDTH=8, out_ready=1 unless stated.
- a=0x00, b=0x00, carryin=0, accept → out_valid exactly 8 cycles after the accept edge; sum=0x00, carryout=0, overflow=0; in_ready returns 1 the cycle after the handshake.
- a=0xFF, b=0x01, carryin=0 → sum=0x00, carryout=1, overflow=0. Then a=0x7F, b=0x01, carryin=0 → sum=0x80, carryout=0, overflow=1.
- a=0xFF, b=0xFF, carryin=1 → sum=0xFF, carryout=1, overflow=0. Then a=0x80, b=0x80, carryin=0 → sum=0x00, carryout=1, overflow=1.
- Backpressure: a=0x35, b=0x4A, carryin=0, out_ready=0 for 5 cycles in DONE → out_valid stays 1 and sum=0x7F is held; in_ready=0 throughout. Raise out_ready → out_valid drops, in_ready=1 on the next cycle.
- Reset mid-operation: accept a=0x12, b=0x34, assert reset at ADD cycle 3 → in_ready=1 and out_valid=0 immediately; no out_valid afterwards. Then a=0x12, b=0x34 → sum=0x46.
- Ignored input: hold in_valid=1 with changing a/b during ADD → the result reflects only the pair accepted at E0. Back-to-back ops: accept interval = 10 cycles.
